// File: rtl/clk_rate_ctrl.sv
// rtl/clk_rate_ctrl.sv - clock-enable rate controller with /8-aligned, gapped rate switching
// Phase counter drives en_2/en_4/en_8; clk_en follows cur_rate, which only changes at a /8 boundary.
module clk_rate_ctrl #(
  parameter int         GAP_CYCLES   = 2,
  parameter logic [1:0] DEFAULT_RATE = 2'd0
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       enable,
  input  logic       rate_req,
  input  logic [1:0] rate_sel,
  output logic       rate_ack,
  output logic       busy,
  output logic [1:0] cur_rate,
  output logic       clk_en,
  output logic       en_2,
  output logic       en_4,
  output logic       en_8,
  output logic [2:0] phase
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, GAP} state_t;

  localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] gap_cnt;
  logic [2:0] gap_cnt_nxt;
  logic [2:0] phase_nxt;
  logic [1:0] pend_rate;
  logic [1:0] pend_rate_nxt;
  logic [1:0] cur_rate_nxt;
  logic       ack_nxt;
  logic       strobe_act;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ack_nxt       = 1'b0;
    cur_rate_nxt  = cur_rate;
    pend_rate_nxt = pend_rate;
    gap_cnt_nxt   = gap_cnt;
    unique case (state)
      IDLE: begin
        // back-to-back requests are dropped so rate_ack can never stretch over two cycles
        if (rate_req && !rate_ack) begin
          cur_rate_nxt = rate_sel;
          ack_nxt      = 1'b1;
        end
        if (enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (rate_req) begin
          if (rate_sel == cur_rate) begin
            ack_nxt = !rate_ack;
          end else begin
            pend_rate_nxt = rate_sel;
            state_nxt     = PEND;
          end
        end
      end
      PEND: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (phase == 3'd7) begin
          cur_rate_nxt = pend_rate;
          if (GAP_LOAD == 3'd0) begin
            state_nxt = RUN;
            ack_nxt   = 1'b1;
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (gap_cnt <= 3'd1) begin
          state_nxt = RUN;
          ack_nxt   = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != GAP) begin
      gap_cnt_nxt = 3'd0;
    end
  end

  // phase only advances while counting continues; the PEND exit at 7 wraps to 0 naturally
  always_comb begin
    phase_nxt = 3'd0;
    if ((state == RUN || state == PEND) && (state_nxt == RUN || state_nxt == PEND)) begin
      phase_nxt = phase + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      phase     <= 3'd0;
      gap_cnt   <= 3'd0;
      cur_rate  <= DEFAULT_RATE;
      pend_rate <= 2'd0;
      rate_ack  <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      gap_cnt   <= gap_cnt_nxt;
      cur_rate  <= cur_rate_nxt;
      pend_rate <= pend_rate_nxt;
      rate_ack  <= ack_nxt;
    end
  end

  assign strobe_act = (state == RUN) || (state == PEND);
  assign busy       = (state == PEND) || (state == GAP);
  assign en_2       = strobe_act && phase[0];
  assign en_4       = strobe_act && (phase[1:0] == 2'd3);
  assign en_8       = strobe_act && (phase == 3'd7);

  always_comb begin
    clk_en = 1'b0;
    unique case (cur_rate)
      2'd0: clk_en = strobe_act;
      2'd1: clk_en = en_2;
      2'd2: clk_en = en_4;
      2'd3: clk_en = en_8;
      default: clk_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// tb/tb_clk_rate_ctrl.sv - randomized scoreboard bench for clk_rate_ctrl
module tb_clk_rate_ctrl;

  localparam int         GAP = 2;
  localparam logic [1:0] DEF = 2'd0;
  localparam int M_IDLE = 0, M_RUN = 1, M_PEND = 2, M_GAP = 3;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       rate_req = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       rate_ack, busy, clk_en, en_2, en_4, en_8;
  logic [1:0] cur_rate;
  logic [2:0] phase;

  clk_rate_ctrl #(.GAP_CYCLES(GAP), .DEFAULT_RATE(DEF)) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .rate_req(rate_req), .rate_sel(rate_sel),
    .rate_ack(rate_ack), .busy(busy), .cur_rate(cur_rate), .clk_en(clk_en),
    .en_2(en_2), .en_4(en_4), .en_8(en_8), .phase(phase)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_v;
  bit          in_reset = 1'b1;
  wire  [10:0] act_vec = {rate_ack, busy, cur_rate, clk_en, en_2, en_4, en_8, phase};

  // reference model: ph counts cycles since counting began, strobes derived arithmetically
  int         m_mode, m_ph, m_gap;
  logic [1:0] m_rate, m_pend;
  bit         m_ack;

  task automatic model_reset();
    m_mode = M_IDLE; m_ph = 0; m_gap = 0; m_rate = DEF; m_pend = 2'd0; m_ack = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit req, input logic [1:0] sel);
    bit prev_ack;
    prev_ack = m_ack;
    m_ack = 1'b0;
    if (m_mode == M_IDLE) begin
      if (req && !prev_ack) begin m_rate = sel; m_ack = 1'b1; end
      if (en) m_mode = M_RUN;
      m_ph = 0;
    end else if (!en) begin
      m_mode = M_IDLE; m_ph = 0;
    end else if (m_mode == M_RUN) begin
      m_ph++;
      if (req) begin
        if (sel == m_rate) m_ack = !prev_ack;
        else begin m_pend = sel; m_mode = M_PEND; end
      end
    end else if (m_mode == M_PEND) begin
      if (m_ph % 8 == 7) begin
        m_rate = m_pend; m_ph = 0;
        if (GAP > 0) begin m_mode = M_GAP; m_gap = GAP; end
        else begin m_mode = M_RUN; m_ack = 1'b1; end
      end else m_ph++;
    end else begin
      if (m_gap == 1) begin m_mode = M_RUN; m_ack = 1'b1; m_ph = 0; end
      else m_gap--;
    end
  endtask

  function automatic logic [10:0] model_out();
    bit         act;
    int         p, div;
    logic [2:0] p3;
    act = (m_mode == M_RUN) || (m_mode == M_PEND);
    p   = act ? (m_ph % 8) : 0;
    div = 1 << m_rate;
    p3  = 3'(p);
    return {m_ack, (m_mode == M_PEND) || (m_mode == M_GAP), m_rate,
            act && ((p + 1) % div == 0), act && (p % 2 == 1), act && (p % 4 == 3),
            act && (p == 7), p3};
  endfunction

  task automatic check_reset(input string name);
    n_cmp++;
    if (act_vec !== {2'b00, DEF, 4'b0000, 3'b000}) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (ack busy rate clk_en en2 en4 en8 phase)",
               name, act_vec, {2'b00, DEF, 4'b0000, 3'b000});
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (!in_reset) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: got %b required an expected entry", act_vec);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_vec !== exp_v) begin
          n_bad++;
          $display("FAIL cycle_outputs @%0t: got %b required %b (ack busy rate clk_en en2 en4 en8 phase)",
                   $time, act_vec, exp_v);
        end
      end
    end
  end

  initial begin
    bit en_r;
    bit rst_pending;
    en_r = 1'b1;
    rst_pending = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    #1 check_reset("reset_initial");
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) begin reset = 1'b1; in_reset = 1'b0; end
      if (cyc == 1000 || cyc == 2500) rst_pending = 1'b1;
      if (rst_pending && m_mode == M_GAP) begin
        reset = 1'b0; in_reset = 1'b1;
        #1 check_reset("reset_during_gap");
        @(negedge CLK);
        reset = 1'b1; in_reset = 1'b0;
        model_reset();
        rst_pending = 1'b0;
      end
      if ($urandom_range(99) < 4) en_r = !en_r;
      enable   = en_r;
      rate_req = ($urandom_range(99) < 20);
      rate_sel = 2'($urandom_range(3));
      model_step(enable, rate_req, rate_sel);
      exp_q.push_back(model_out());
    end
    @(negedge CLK);
    rate_req = 1'b0;
    in_reset = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
